// File: rtl/id_stage_pkg.sv
// Shared decode constants, ALU op/sel codes and the decoded-instruction record for the ID stage.
package id_stage_pkg;
    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;
    localparam int AluSelBus  = 3;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                           OP_XORI    = 6'h0E, OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_ADDU = 6'h21,
                           FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR  = 6'h25, FN_XOR  = 6'h26,
                           FN_NOR  = 6'h27, FN_SLT = 6'h2A;

    localparam logic [AluOpBus-1:0] EXE_NOP_OP  = 8'h00, EXE_AND_OP  = 8'h24, EXE_OR_OP   = 8'h25,
                                    EXE_XOR_OP  = 8'h26, EXE_NOR_OP  = 8'h27, EXE_SLL_OP  = 8'h7C,
                                    EXE_SRL_OP  = 8'h02, EXE_SRA_OP  = 8'h03, EXE_SLT_OP  = 8'h2A,
                                    EXE_ADDU_OP = 8'h21, EXE_SUBU_OP = 8'h23, EXE_ADDIU_OP = 8'h56,
                                    EXE_LW_OP   = 8'hE3, EXE_SW_OP   = 8'hEB;

    localparam logic [AluSelBus-1:0] EXE_RES_NOP = 3'b000, EXE_RES_LOGIC = 3'b001, EXE_RES_SHIFT = 3'b010,
                                     EXE_RES_ARITH = 3'b100, EXE_RES_LOAD_STORE = 3'b111;

    typedef struct packed {
        logic                  re1;
        logic                  re2;
        logic [RegAddrBus-1:0] rs;
        logic [RegAddrBus-1:0] rt;
        logic [AluOpBus-1:0]   aluop;
        logic [AluSelBus-1:0]  alusel;
        logic                  op1_shamt;
        logic                  op2_imm;
        logic [RegBus-1:0]     imm;
        logic [4:0]            shamt;
        logic                  we;
        logic [RegAddrBus-1:0] waddr;
        logic                  mem_re;
        logic                  mem_we;
    } dec_t;
endpackage

// File: rtl/id_stage_if.sv
// ID/EX pipeline register bundle: driven by id_stage (master), consumed by EX (slave).
interface id_stage_if;
    import id_stage_pkg::*;
    logic                  ex_valid_o;
    logic [AluOpBus-1:0]   ex_aluop_o;
    logic [AluSelBus-1:0]  ex_alusel_o;
    logic [RegBus-1:0]     ex_op1_o;
    logic [RegBus-1:0]     ex_op2_o;
    logic [RegBus-1:0]     ex_store_data_o;
    logic [RegBus-1:0]     ex_pc_o;
    logic                  ex_we_o;
    logic [RegAddrBus-1:0] ex_waddr_o;
    logic                  ex_mem_re_o;
    logic                  ex_mem_we_o;

    modport master (output ex_valid_o, ex_aluop_o, ex_alusel_o, ex_op1_o, ex_op2_o, ex_store_data_o,
                           ex_pc_o, ex_we_o, ex_waddr_o, ex_mem_re_o, ex_mem_we_o);
    modport slave  (input  ex_valid_o, ex_aluop_o, ex_alusel_o, ex_op1_o, ex_op2_o, ex_store_data_o,
                           ex_pc_o, ex_we_o, ex_waddr_o, ex_mem_re_o, ex_mem_we_o);
endinterface

// File: rtl/id_decode.sv
// Combinational instruction decoder: read ports, immediate form, ALU codes, destination, memory flags.
module id_decode
    import id_stage_pkg::*;
(
    input  logic [31:0] inst_i,
    output dec_t        dec_o
);
    logic [15:0] imm;
    assign imm = inst_i[15:0];

    always_comb begin
        dec_o       = '0;
        dec_o.rs    = inst_i[25:21];
        dec_o.rt    = inst_i[20:16];
        dec_o.shamt = inst_i[10:6];
        case (inst_i[31:26])
            OP_SPECIAL: begin
                // the all-zero word is the canonical NOP, not SLL $0 (which would claim a write)
                if (inst_i != '0) begin
                    dec_o.re1   = 1'b1;
                    dec_o.re2   = 1'b1;
                    dec_o.we    = 1'b1;
                    dec_o.waddr = inst_i[15:11];
                    case (inst_i[5:0])
                        FN_ADDU: {dec_o.aluop, dec_o.alusel} = {EXE_ADDU_OP, EXE_RES_ARITH};
                        FN_SUBU: {dec_o.aluop, dec_o.alusel} = {EXE_SUBU_OP, EXE_RES_ARITH};
                        FN_SLT:  {dec_o.aluop, dec_o.alusel} = {EXE_SLT_OP,  EXE_RES_ARITH};
                        FN_AND:  {dec_o.aluop, dec_o.alusel} = {EXE_AND_OP,  EXE_RES_LOGIC};
                        FN_OR:   {dec_o.aluop, dec_o.alusel} = {EXE_OR_OP,   EXE_RES_LOGIC};
                        FN_XOR:  {dec_o.aluop, dec_o.alusel} = {EXE_XOR_OP,  EXE_RES_LOGIC};
                        FN_NOR:  {dec_o.aluop, dec_o.alusel} = {EXE_NOR_OP,  EXE_RES_LOGIC};
                        FN_SLL, FN_SRL, FN_SRA: begin
                            dec_o.re1       = 1'b0;
                            dec_o.op1_shamt = 1'b1;
                            dec_o.alusel    = EXE_RES_SHIFT;
                            dec_o.aluop     = (inst_i[5:0] == FN_SLL) ? EXE_SLL_OP :
                                              (inst_i[5:0] == FN_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
                        end
                        default: begin
                            dec_o.re1   = 1'b0;
                            dec_o.re2   = 1'b0;
                            dec_o.we    = 1'b0;
                            dec_o.waddr = '0;
                        end
                    endcase
                end
            end
            OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: begin
                dec_o.re1     = 1'b1;
                dec_o.we      = 1'b1;
                dec_o.waddr   = inst_i[20:16];
                dec_o.op2_imm = 1'b1;
                dec_o.imm     = {{16{imm[15]}}, imm};
                case (inst_i[31:26])
                    OP_ADDIU: {dec_o.aluop, dec_o.alusel} = {EXE_ADDIU_OP, EXE_RES_ARITH};
                    OP_ANDI: begin
                        {dec_o.aluop, dec_o.alusel} = {EXE_AND_OP, EXE_RES_LOGIC};
                        dec_o.imm = {16'h0, imm};
                    end
                    OP_ORI: begin
                        {dec_o.aluop, dec_o.alusel} = {EXE_OR_OP, EXE_RES_LOGIC};
                        dec_o.imm = {16'h0, imm};
                    end
                    OP_XORI: begin
                        {dec_o.aluop, dec_o.alusel} = {EXE_XOR_OP, EXE_RES_LOGIC};
                        dec_o.imm = {16'h0, imm};
                    end
                    OP_LUI: begin
                        {dec_o.aluop, dec_o.alusel} = {EXE_OR_OP, EXE_RES_LOGIC};
                        dec_o.re1 = 1'b0;
                        dec_o.imm = {imm, 16'h0};
                    end
                    OP_LW: begin
                        {dec_o.aluop, dec_o.alusel} = {EXE_LW_OP, EXE_RES_LOAD_STORE};
                        dec_o.mem_re = 1'b1;
                    end
                    default: begin
                        {dec_o.aluop, dec_o.alusel} = {EXE_SW_OP, EXE_RES_LOAD_STORE};
                        dec_o.re2    = 1'b1;
                        dec_o.we     = 1'b0;
                        dec_o.waddr  = '0;
                        dec_o.mem_we = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/id_stage.sv
// MIPS ID stage: decode, operand resolution, load-use hazard detection and the ID/EX register.
// Build option: define ID_FWD_EN for EX/MEM forwarding; otherwise operands come only from regfile.
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic        reg1_re_o,
    output logic        reg2_re_o,
    output logic [4:0]  reg1_addr_o,
    output logic [4:0]  reg2_addr_o,
    input  logic [31:0] reg1_data_i,
    input  logic [31:0] reg2_data_i,
    input  logic        ex_we_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        ex_is_load_i,
    input  logic        mem_we_i,
    input  logic [4:0]  mem_waddr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        stall_req_o,
    id_stage_if.master  idex
);
    dec_t        dec;
    logic        ex_hit1, ex_hit2, mem_hit1, mem_hit2, hazard;
    logic [31:0] rs_val, rt_val;

    id_decode u_dec (.inst_i(inst_i), .dec_o(dec));

    assign reg1_re_o   = dec.re1 & inst_valid_i & ~rst;
    assign reg2_re_o   = dec.re2 & inst_valid_i & ~rst;
    assign reg1_addr_o = dec.rs;
    assign reg2_addr_o = dec.rt;

    // $0 never matches a producer, so a write to register 0 can neither forward nor stall
    assign ex_hit1  = reg1_re_o && reg1_addr_o != '0 && ex_we_i  && ex_waddr_i  == reg1_addr_o;
    assign ex_hit2  = reg2_re_o && reg2_addr_o != '0 && ex_we_i  && ex_waddr_i  == reg2_addr_o;
    assign mem_hit1 = reg1_re_o && reg1_addr_o != '0 && mem_we_i && mem_waddr_i == reg1_addr_o;
    assign mem_hit2 = reg2_re_o && reg2_addr_o != '0 && mem_we_i && mem_waddr_i == reg2_addr_o;

`ifdef ID_FWD_EN
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (ex_hit1)                              rs_val = ex_wdata_i;
        else if (mem_hit1)                        rs_val = mem_wdata_i;
        else if (reg1_re_o && reg1_addr_o != '0) rs_val = reg1_data_i;
        if (ex_hit2)                              rt_val = ex_wdata_i;
        else if (mem_hit2)                        rt_val = mem_wdata_i;
        else if (reg2_re_o && reg2_addr_o != '0) rt_val = reg2_data_i;
    end
    assign hazard = ex_is_load_i & (ex_hit1 | ex_hit2);
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};
    assign rs_val = (reg1_re_o && reg1_addr_o != '0) ? reg1_data_i : '0;
    assign rt_val = (reg2_re_o && reg2_addr_o != '0) ? reg2_data_i : '0;
    // without bypass muxes, any in-flight producer must drain into regfile first
    assign hazard = ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2;
`endif

    assign stall_req_o = hazard & ~flush_i & ~rst;

    always_ff @(posedge clk) begin
        if (rst || !inst_valid_i || flush_i || stall_req_o) begin
            idex.ex_valid_o      <= 1'b0;
            idex.ex_aluop_o      <= EXE_NOP_OP;
            idex.ex_alusel_o     <= EXE_RES_NOP;
            idex.ex_op1_o        <= '0;
            idex.ex_op2_o        <= '0;
            idex.ex_store_data_o <= '0;
            idex.ex_pc_o         <= '0;
            idex.ex_we_o         <= 1'b0;
            idex.ex_waddr_o      <= '0;
            idex.ex_mem_re_o     <= 1'b0;
            idex.ex_mem_we_o     <= 1'b0;
        end else begin
            idex.ex_valid_o      <= 1'b1;
            idex.ex_aluop_o      <= dec.aluop;
            idex.ex_alusel_o     <= dec.alusel;
            idex.ex_op1_o        <= dec.op1_shamt ? {27'h0, dec.shamt} : rs_val;
            idex.ex_op2_o        <= dec.op2_imm ? dec.imm : rt_val;
            idex.ex_store_data_o <= dec.mem_we ? rt_val : '0;
            idex.ex_pc_o         <= pc_i;
            idex.ex_we_o         <= dec.we;
            idex.ex_waddr_o      <= dec.waddr;
            idex.ex_mem_re_o     <= dec.mem_re;
            idex.ex_mem_we_o     <= dec.mem_we;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage; expectations follow the ID_FWD_EN build option.
module tb_id_stage;
    import id_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, inst_valid_i, flush_i;
    logic [31:0] inst_i, pc_i;
    logic        reg1_re_o, reg2_re_o, stall_req_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_we_i, ex_is_load_i, mem_we_i;
    logic [4:0]  ex_waddr_i, mem_waddr_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;

    id_stage_if idex();

    id_stage dut (
        .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_i(inst_i), .pc_i(pc_i),
        .flush_i(flush_i), .reg1_re_o(reg1_re_o), .reg2_re_o(reg2_re_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i), .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i),
        .mem_wdata_i(mem_wdata_i), .stall_req_o(stall_req_o), .idex(idex)
    );

    // regfile model (WB bypass is modelled by writing rf before the read)
    logic [31:0] rf [32];
    assign reg1_data_i = rf[reg1_addr_o];
    assign reg2_data_i = rf[reg2_addr_o];

    typedef struct packed {
        logic       valid;
        logic [7:0] aluop;
        logic [2:0] alusel;
        logic [31:0] op1, op2, sd, pc;
        logic       we;
        logic [4:0] wa;
        logic       mre, mwe;
    } idex_t;

    typedef struct packed {
        logic rst, valid;
        logic [31:0] inst, pc;
        logic flush, exwe;
        logic [4:0] exwa;
        logic [31:0] exwd;
        logic exld, mwe;
        logic [4:0] mwa;
        logic [31:0] mwd;
        logic wbwe;
        logic [4:0] wbwa;
        logic [31:0] wbwd;
    } stim_t;

    idex_t got;
    assign got = {idex.ex_valid_o, idex.ex_aluop_o, idex.ex_alusel_o, idex.ex_op1_o, idex.ex_op2_o,
                  idex.ex_store_data_o, idex.ex_pc_o, idex.ex_we_o, idex.ex_waddr_o,
                  idex.ex_mem_re_o, idex.ex_mem_we_o};

    int    pass_cnt = 0, total = 0;
    idex_t q[$];
    stim_t sq[$];
    idex_t eq[$];
    bit    tq[$];
    idex_t exp_r;

    localparam idex_t BUB = '0;

    function automatic idex_t mk(logic v, logic [7:0] op, logic [2:0] sel, logic [31:0] a, b, sd, pc,
                                 logic we, logic [4:0] wa, logic mre, logic mwe);
        mk = {v, op, sel, a, b, sd, pc, we, wa, mre, mwe};
    endfunction

    function automatic logic [31:0] enc_r(logic [5:0] fn, logic [4:0] rs, rt, rd, sh);
        enc_r = {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, rt, logic [15:0] imm);
        enc_i = {op, rs, rt, imm};
    endfunction

    function automatic stim_t sdef(logic [31:0] inst, logic [31:0] pc);
        sdef = '0;
        sdef.valid = 1'b1;
        sdef.inst = inst;
        sdef.pc = pc;
    endfunction

    function automatic void add(stim_t s, idex_t e, bit st);
        sq.push_back(s);
        eq.push_back(e);
        tq.push_back(st);
    endfunction

    task automatic drive(stim_t s);
        rst = s.rst; inst_valid_i = s.valid; inst_i = s.inst; pc_i = s.pc; flush_i = s.flush;
        ex_we_i = s.exwe; ex_waddr_i = s.exwa; ex_wdata_i = s.exwd; ex_is_load_i = s.exld;
        mem_we_i = s.mwe; mem_waddr_i = s.mwa; mem_wdata_i = s.mwd;
        if (s.wbwe) rf[s.wbwa] = s.wbwd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s;
        s = sdef(enc_r(FN_ADDU, 5'd4, 5'd4, 5'd6, 5'd0), 32'h40);
        s.rst = 1'b1; s.exwe = 1'b1; s.exwa = 5'd4; s.exld = 1'b1;
        drive(s);
        #1;
        total++;
        if (stall_req_o !== 1'b0 || reg1_re_o !== 1'b0 || reg2_re_o !== 1'b0)
            $display("FAIL reset_comb: stall=%b re1=%b re2=%b, required 0 0 0", stall_req_o, reg1_re_o, reg2_re_o);
        else pass_cnt++;
        q.push_back(BUB);
        tick();
        exp_r = q.pop_front();
        total++;
        if (got !== exp_r) $display("FAIL reset_idex: got %h required %h", got, exp_r);
        else pass_cnt++;
    endtask

    task automatic test_decode_b2b();
        stim_t s;
        add(sdef(enc_i(OP_ORI, 5'd0, 5'd1, 16'h1234), 32'h100),
            mk(1, EXE_OR_OP, EXE_RES_LOGIC, 0, 32'h1234, 0, 32'h100, 1, 1, 0, 0), 0);
        add(sdef(enc_i(OP_ADDIU, 5'd3, 5'd2, 16'hFFFC), 32'h104),
            mk(1, EXE_ADDIU_OP, EXE_RES_ARITH, 32'h01010003, 32'hFFFFFFFC, 0, 32'h104, 1, 2, 0, 0), 0);
        add(sdef(enc_i(OP_ANDI, 5'd3, 5'd2, 16'h8001), 32'h108),
            mk(1, EXE_AND_OP, EXE_RES_LOGIC, 32'h01010003, 32'h00008001, 0, 32'h108, 1, 2, 0, 0), 0);
        add(sdef(enc_i(OP_XORI, 5'd3, 5'd2, 16'hF0F0), 32'h10C),
            mk(1, EXE_XOR_OP, EXE_RES_LOGIC, 32'h01010003, 32'h0000F0F0, 0, 32'h10C, 1, 2, 0, 0), 0);
        add(sdef(enc_i(OP_LUI, 5'd0, 5'd7, 16'hABCD), 32'h110),
            mk(1, EXE_OR_OP, EXE_RES_LOGIC, 0, 32'hABCD0000, 0, 32'h110, 1, 7, 0, 0), 0);
        add(sdef(enc_i(OP_LW, 5'd5, 5'd4, 16'h0008), 32'h114),
            mk(1, EXE_LW_OP, EXE_RES_LOAD_STORE, 32'h01010005, 32'h8, 0, 32'h114, 1, 4, 1, 0), 0);
        add(sdef(enc_i(OP_SW, 5'd5, 5'd6, 16'hFFF8), 32'h118),
            mk(1, EXE_SW_OP, EXE_RES_LOAD_STORE, 32'h01010005, 32'hFFFFFFF8, 32'h01010006, 32'h118, 0, 0, 0, 1), 0);
        add(sdef(enc_r(FN_SLL, 5'd0, 5'd8, 5'd9, 5'd5), 32'h11C),
            mk(1, EXE_SLL_OP, EXE_RES_SHIFT, 32'h5, 32'h01010008, 0, 32'h11C, 1, 9, 0, 0), 0);
        add(sdef(enc_r(FN_SRA, 5'd0, 5'd8, 5'd9, 5'd31), 32'h120),
            mk(1, EXE_SRA_OP, EXE_RES_SHIFT, 32'd31, 32'h01010008, 0, 32'h120, 1, 9, 0, 0), 0);
        add(sdef(enc_r(FN_SRL, 5'd0, 5'd8, 5'd10, 5'd1), 32'h124),
            mk(1, EXE_SRL_OP, EXE_RES_SHIFT, 32'd1, 32'h01010008, 0, 32'h124, 1, 10, 0, 0), 0);
        add(sdef(enc_r(FN_SUBU, 5'd1, 5'd2, 5'd3, 5'd0), 32'h128),
            mk(1, EXE_SUBU_OP, EXE_RES_ARITH, 32'h01010001, 32'h01010002, 0, 32'h128, 1, 3, 0, 0), 0);
        add(sdef(enc_r(FN_NOR, 5'd1, 5'd2, 5'd3, 5'd0), 32'h12C),
            mk(1, EXE_NOR_OP, EXE_RES_LOGIC, 32'h01010001, 32'h01010002, 0, 32'h12C, 1, 3, 0, 0), 0);
        add(sdef(enc_r(FN_SLT, 5'd1, 5'd2, 5'd3, 5'd0), 32'h130),
            mk(1, EXE_SLT_OP, EXE_RES_ARITH, 32'h01010001, 32'h01010002, 0, 32'h130, 1, 3, 0, 0), 0);
        add(sdef(32'h0, 32'h134), mk(1, EXE_NOP_OP, EXE_RES_NOP, 0, 0, 0, 32'h134, 0, 0, 0, 0), 0);
        add(sdef({6'h3F, 26'h1234567}, 32'h138), mk(1, EXE_NOP_OP, EXE_RES_NOP, 0, 0, 0, 32'h138, 0, 0, 0, 0), 0);
        add(sdef(enc_r(6'h08, 5'd1, 5'd2, 5'd3, 5'd0), 32'h13C),
            mk(1, EXE_NOP_OP, EXE_RES_NOP, 0, 0, 0, 32'h13C, 0, 0, 0, 0), 0);
        s = sdef(enc_i(OP_ORI, 5'd1, 5'd1, 16'h1), 32'h140); s.valid = 1'b0;
        add(s, BUB, 0);
        foreach (sq[i]) begin
            drive(sq[i]);
            #1;
            total++;
            if (stall_req_o !== tq[i]) $display("FAIL decode_stall[%0d]: got %b required %b", i, stall_req_o, tq[i]);
            else pass_cnt++;
            q.push_back(eq[i]);
            tick();
            exp_r = q.pop_front();
            total++;
            if (got !== exp_r) $display("FAIL decode_idex[%0d]: got %h required %h", i, got, exp_r);
            else pass_cnt++;
        end
        sq.delete(); eq.delete(); tq.delete();
        // read-enable pattern: LUI reads nothing, shifts read rt only, SW reads both
        drive(sdef(enc_i(OP_LUI, 5'd3, 5'd7, 16'h1), 32'h0));
        #1;
        total++;
        if ({reg1_re_o, reg2_re_o} !== 2'b00) $display("FAIL re_lui: got %b required 00", {reg1_re_o, reg2_re_o});
        else pass_cnt++;
        drive(sdef(enc_r(FN_SLL, 5'd3, 5'd8, 5'd9, 5'd2), 32'h0));
        #1;
        total++;
        if ({reg1_re_o, reg2_re_o} !== 2'b01) $display("FAIL re_sll: got %b required 01", {reg1_re_o, reg2_re_o});
        else pass_cnt++;
        drive(sdef(enc_i(OP_SW, 5'd5, 5'd6, 16'h0), 32'h0));
        #1;
        total++;
        if ({reg1_re_o, reg2_re_o, reg1_addr_o, reg2_addr_o} !== {2'b11, 5'd5, 5'd6})
            $display("FAIL re_sw: got %b/%0d/%0d required 11/5/6", {reg1_re_o, reg2_re_o}, reg1_addr_o, reg2_addr_o);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_forward();
        stim_t s;
        s = sdef(enc_r(FN_ADDU, 5'd1, 5'd2, 5'd3, 5'd0), 32'h200);
        s.exwe = 1; s.exwa = 5'd1; s.exwd = 32'd5; s.mwe = 1; s.mwa = 5'd2; s.mwd = 32'd7;
`ifdef ID_FWD_EN
        add(s, mk(1, EXE_ADDU_OP, EXE_RES_ARITH, 32'd5, 32'd7, 0, 32'h200, 1, 3, 0, 0), 0);
`else
        add(s, BUB, 1);
`endif
        s.mwa = 5'd1; s.mwd = 32'hBAD0_0001; s.pc = 32'h204;
`ifdef ID_FWD_EN
        add(s, mk(1, EXE_ADDU_OP, EXE_RES_ARITH, 32'd5, 32'h01010002, 0, 32'h204, 1, 3, 0, 0), 0);
`else
        add(s, BUB, 1);
`endif
        add(sdef(enc_r(FN_ADDU, 5'd1, 5'd2, 5'd3, 5'd0), 32'h208),
            mk(1, EXE_ADDU_OP, EXE_RES_ARITH, 32'h01010001, 32'h01010002, 0, 32'h208, 1, 3, 0, 0), 0);
        // $0 reads stay zero even with a "load" targeting waddr 0
        s = sdef(enc_r(FN_ADDU, 5'd0, 5'd1, 5'd3, 5'd0), 32'h20C);
        s.exwe = 1; s.exwa = 5'd0; s.exwd = 32'hFFFFFFFF; s.exld = 1; s.mwe = 1; s.mwa = 5'd0; s.mwd = 32'hFFFFFFFF;
        add(s, mk(1, EXE_ADDU_OP, EXE_RES_ARITH, 0, 32'h01010001, 0, 32'h20C, 1, 3, 0, 0), 0);
        foreach (sq[i]) begin
            drive(sq[i]);
            #1;
            total++;
            if (stall_req_o !== tq[i]) $display("FAIL fwd_stall[%0d]: got %b required %b", i, stall_req_o, tq[i]);
            else pass_cnt++;
            q.push_back(eq[i]);
            tick();
            exp_r = q.pop_front();
            total++;
            if (got !== exp_r) $display("FAIL fwd_idex[%0d]: got %h required %h", i, got, exp_r);
            else pass_cnt++;
        end
        sq.delete(); eq.delete(); tq.delete();
    endtask

    task automatic test_load_use();
        stim_t s;
        add(sdef(enc_i(OP_LW, 5'd5, 5'd4, 16'h0), 32'h300),
            mk(1, EXE_LW_OP, EXE_RES_LOAD_STORE, 32'h01010005, 0, 0, 32'h300, 1, 4, 1, 0), 0);
        s = sdef(enc_r(FN_ADDU, 5'd4, 5'd4, 5'd6, 5'd0), 32'h304);
        s.exwe = 1; s.exwa = 5'd4; s.exwd = 32'hDEAD_BEEF; s.exld = 1;
        add(s, BUB, 1);
        s = sdef(enc_r(FN_ADDU, 5'd4, 5'd4, 5'd6, 5'd0), 32'h304);
        s.mwe = 1; s.mwa = 5'd4; s.mwd = 32'h44;
`ifdef ID_FWD_EN
        add(s, mk(1, EXE_ADDU_OP, EXE_RES_ARITH, 32'h44, 32'h44, 0, 32'h304, 1, 6, 0, 0), 0);
`else
        add(s, BUB, 1);
        s = sdef(enc_r(FN_ADDU, 5'd4, 5'd4, 5'd6, 5'd0), 32'h304);
        s.wbwe = 1; s.wbwa = 5'd4; s.wbwd = 32'h44;
        add(s, mk(1, EXE_ADDU_OP, EXE_RES_ARITH, 32'h44, 32'h44, 0, 32'h304, 1, 6, 0, 0), 0);
`endif
        // flush beats the stall
        s = sdef(enc_r(FN_ADDU, 5'd4, 5'd4, 5'd6, 5'd0), 32'h308);
        s.exwe = 1; s.exwa = 5'd4; s.exld = 1; s.flush = 1;
        add(s, BUB, 0);
        // reset mid-stream after a real instruction
        add(sdef(enc_i(OP_ORI, 5'd0, 5'd9, 16'h55), 32'h30C),
            mk(1, EXE_OR_OP, EXE_RES_LOGIC, 0, 32'h55, 0, 32'h30C, 1, 9, 0, 0), 0);
        s = sdef(enc_r(FN_ADDU, 5'd4, 5'd4, 5'd6, 5'd0), 32'h310);
        s.rst = 1; s.exwe = 1; s.exwa = 5'd4; s.exld = 1;
        add(s, BUB, 0);
        foreach (sq[i]) begin
            drive(sq[i]);
            #1;
            total++;
            if (stall_req_o !== tq[i]) $display("FAIL lu_stall[%0d]: got %b required %b", i, stall_req_o, tq[i]);
            else pass_cnt++;
            q.push_back(eq[i]);
            tick();
            exp_r = q.pop_front();
            total++;
            if (got !== exp_r) $display("FAIL lu_idex[%0d]: got %h required %h", i, got, exp_r);
            else pass_cnt++;
        end
        sq.delete(); eq.delete(); tq.delete();
    endtask

    task automatic test_ex_dep();
        stim_t s;
        s = sdef(enc_r(FN_ADDU, 5'd1, 5'd1, 5'd3, 5'd0), 32'h400);
        s.exwe = 1; s.exwa = 5'd1; s.exwd = 32'h99;
`ifdef ID_FWD_EN
        add(s, mk(1, EXE_ADDU_OP, EXE_RES_ARITH, 32'h99, 32'h99, 0, 32'h400, 1, 3, 0, 0), 0);
`else
        add(s, BUB, 1);
        s = sdef(enc_r(FN_ADDU, 5'd1, 5'd1, 5'd3, 5'd0), 32'h400);
        s.mwe = 1; s.mwa = 5'd1; s.mwd = 32'h99;
        add(s, BUB, 1);
        s = sdef(enc_r(FN_ADDU, 5'd1, 5'd1, 5'd3, 5'd0), 32'h400);
        s.wbwe = 1; s.wbwa = 5'd1; s.wbwd = 32'h99;
        add(s, mk(1, EXE_ADDU_OP, EXE_RES_ARITH, 32'h99, 32'h99, 0, 32'h400, 1, 3, 0, 0), 0);
`endif
        foreach (sq[i]) begin
            drive(sq[i]);
            #1;
            total++;
            if (stall_req_o !== tq[i]) $display("FAIL exdep_stall[%0d]: got %b required %b", i, stall_req_o, tq[i]);
            else pass_cnt++;
            q.push_back(eq[i]);
            tick();
            exp_r = q.pop_front();
            total++;
            if (got !== exp_r) $display("FAIL exdep_idex[%0d]: got %h required %h", i, got, exp_r);
            else pass_cnt++;
        end
        sq.delete(); eq.delete(); tq.delete();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0101_0000 + i;
        test_reset();
        test_decode_b2b();
        test_forward();
        test_load_use();
        test_ex_dep();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
